// File: rtl/serial_panel_io.sv
// serial_panel_io: free-running serial front-panel engine with output-chain shift, input-chain capture and per-bit debounce
module serial_panel_io #(
  parameter int OUT_WIDTH      = 16,
  parameter int IN_WIDTH       = 21,
  parameter int CLK_DIV        = 4,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic                 i_CLK,
  input  logic                 i_RESET,
  input  logic [OUT_WIDTH-1:0] i_OutData,
  input  logic                 i_InData,
  output logic                 o_SerCLK,
  output logic                 o_OutData,
  output logic                 o_OutLatch,
  output logic                 o_InLatch,
  output logic [IN_WIDTH-1:0]  o_InRaw,
  output logic [IN_WIDTH-1:0]  o_InStable,
  output logic [IN_WIDTH-1:0]  o_Press,
  output logic [IN_WIDTH-1:0]  o_Release,
  output logic                 o_ScanDone
);
  localparam int N  = OUT_WIDTH > IN_WIDTH ? OUT_WIDTH : IN_WIDTH;
  localparam int PW = $clog2(2 * CLK_DIV) > 0 ? $clog2(2 * CLK_DIV) : 1;
  localparam int BW = N > 1 ? $clog2(N) : 1;
  localparam int DW = DEBOUNCE_SCANS > 1 ? $clog2(DEBOUNCE_SCANS) : 1;
  localparam logic [PW-1:0] PH_HI  = PW'(CLK_DIV);
  localparam logic [PW-1:0] PH_END = PW'(2 * CLK_DIV - 1);
  localparam logic [BW-1:0] BIT_END = BW'(N - 1);
  localparam logic [DW-1:0] DEB_M1 = DW'(DEBOUNCE_SCANS - 1);
  typedef enum logic [1:0] {LOAD, SHIFT, LATCH} state_t;
  state_t st, nxt_st;
  logic [PW-1:0] ph, nxt_ph;
  logic [BW-1:0] bit_idx, nxt_bit;
  logic run, done;
  logic [N-1:0] osr, src;
  logic [IN_WIDTH-1:0] isr, flip;
  logic [DW-1:0] cnt [IN_WIDTH];
  logic [DW-1:0] cnt_n [IN_WIDTH];
  // Outputs are registered from the next position so cycle 0 already shows LOAD.
  always_comb begin
    nxt_st  = st;
    nxt_ph  = ph;
    nxt_bit = bit_idx;
    if (run) begin
      nxt_ph = ph == PH_END ? '0 : ph + 1'b1;
      if (ph == PH_END) begin
        nxt_st  = st == LOAD ? SHIFT : st == SHIFT ? (bit_idx == BIT_END ? LATCH : SHIFT) : LOAD;
        nxt_bit = st == SHIFT && bit_idx != BIT_END ? bit_idx + 1'b1 : '0;
      end
    end
    src  = nxt_bit == '0 ? N'(i_OutData) : osr;
    done = nxt_st == LATCH && nxt_ph == PH_END;
    flip  = '0;
    cnt_n = cnt;
    for (int i = 0; i < IN_WIDTH; i++) begin
      flip[i]  = (isr[i] ^ o_InStable[i]) && cnt[i] == DEB_M1;
      cnt_n[i] = (isr[i] ^ o_InStable[i]) && !flip[i] ? cnt[i] + 1'b1 : '0;
    end
  end
  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      st         <= LOAD;
      ph         <= '0;
      bit_idx    <= '0;
      run        <= 1'b0;
      osr        <= '0;
      isr        <= '0;
      cnt        <= '{default: '0};
      o_SerCLK   <= 1'b0;
      o_OutData  <= 1'b0;
      o_OutLatch <= 1'b0;
      o_InLatch  <= 1'b0;
      o_InRaw    <= '0;
      o_InStable <= '0;
      o_Press    <= '0;
      o_Release  <= '0;
      o_ScanDone <= 1'b0;
    end else begin
      run        <= 1'b1;
      st         <= nxt_st;
      ph         <= nxt_ph;
      bit_idx    <= nxt_bit;
      o_SerCLK   <= nxt_st == SHIFT && nxt_ph >= PH_HI;
      o_InLatch  <= nxt_st == LOAD;
      o_OutLatch <= nxt_st == LATCH;
      if (nxt_st == SHIFT && nxt_ph == '0) begin
        o_OutData <= src[N-1];
        osr       <= src << 1;
      end
      if (nxt_st == SHIFT && nxt_ph == PH_HI && int'(nxt_bit) < IN_WIDTH)
        isr <= (isr << 1) | IN_WIDTH'(i_InData);
      o_ScanDone <= done;
      o_Press    <= done ? flip & isr : '0;
      o_Release  <= done ? flip & ~isr : '0;
      if (done) begin
        o_InRaw    <= isr;
        o_InStable <= o_InStable ^ flip;
        cnt        <= cnt_n;
      end
    end
  end
endmodule

// File: tb/tb_serial_panel_io.sv
// tb_serial_panel_io: randomized self-checking bench with physical chain models and a frame-level reference model
module tb_serial_panel_io;
  localparam int IW = 21, CD = 4, DB = 4, N = 21, P = 8, F = 184;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic [15:0] od = '0;
  logic in_d, sck, o_dat, olat, ilat, done;
  logic [20:0] raw, stab, prs, rel;
  logic [7:0] b_od = '0;
  logic b_in = 1'b0;
  logic b_sck, b_dat, b_olat, b_ilat, b_done;
  logic [7:0] b_raw, b_stab, b_prs, b_rel;
  serial_panel_io dut (
    .i_CLK(clk), .i_RESET(rst), .i_OutData(od), .i_InData(in_d),
    .o_SerCLK(sck), .o_OutData(o_dat), .o_OutLatch(olat), .o_InLatch(ilat),
    .o_InRaw(raw), .o_InStable(stab), .o_Press(prs), .o_Release(rel), .o_ScanDone(done)
  );
  serial_panel_io #(.OUT_WIDTH(8), .IN_WIDTH(8), .CLK_DIV(1), .DEBOUNCE_SCANS(1)) dut_b (
    .i_CLK(clk), .i_RESET(rst), .i_OutData(b_od), .i_InData(b_in),
    .o_SerCLK(b_sck), .o_OutData(b_dat), .o_OutLatch(b_olat), .o_InLatch(b_ilat),
    .o_InRaw(b_raw), .o_InStable(b_stab), .o_Press(b_prs), .o_Release(b_rel), .o_ScanDone(b_done)
  );
  // Physical parallel-load input chain: loads while latched, shifts on serial clock rise.
  logic [20:0] phys = '0, ch = '0;
  logic sq = 1'b0;
  assign in_d = ch[20];
  always @(posedge clk) begin
    sq <= sck;
    if (ilat) ch <= phys;
    else if (sck && !sq) ch <= ch << 1;
  end
  int total = 0, bad = 0;
  logic [20:0] m_stab, m_raw;
  int m_cnt [IW];
  int fr, p0_at, n_p3, n_r3;
  task automatic model_clear;
    m_stab = '0; m_raw = '0; fr = 0; p0_at = -1; n_p3 = 0; n_r3 = 0;
    for (int i = 0; i < IW; i++) m_cnt[i] = 0;
  endtask
  task automatic test_reset;
    @(negedge clk);
    rst = 1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if ({sck, o_dat, olat, ilat, done, raw, stab, prs, rel} !== '0) begin
      bad++; $display("FAIL reset_a: got %h want 0", {sck, o_dat, olat, ilat, done, raw, stab, prs, rel});
    end
    total++;
    if ({b_sck, b_dat, b_olat, b_ilat, b_done, b_raw, b_stab, b_prs, b_rel} !== '0) begin
      bad++; $display("FAIL reset_b: got %h want 0", {b_sck, b_dat, b_olat, b_ilat, b_done, b_raw, b_stab, b_prs, b_rel});
    end
    model_clear();
    rst = 0;
    @(posedge clk);
  endtask
  // Runs one full frame from cycle 0, checking timing, serial stream and frame-end results.
  task automatic run_frame(input logic [15:0] v, input logic [20:0] ph, input bit chg, input logic [15:0] nv);
    logic [20:0] exp_o, p, r;
    logic [15:0] oc;
    bit e_sck, e_il, e_ol;
    int k;
    od = v; phys = ph; exp_o = {5'b0, v}; oc = '0;
    for (int c = 0; c < F; c++) begin
      @(negedge clk);
      if (chg && c == 20) od = nv;
      e_il = c < P;
      e_ol = c >= (N + 1) * P;
      e_sck = !e_il && !e_ol && (c % P) >= CD;
      total++;
      if ({sck, ilat, olat} !== {e_sck, e_il, e_ol}) begin
        bad++; $display("FAIL strobes c=%0d: got %b want %b", c, {sck, ilat, olat}, {e_sck, e_il, e_ol});
      end
      if (!e_il && !e_ol) begin
        k = c / P - 1;
        total++;
        if (o_dat !== exp_o[N-1-k]) begin
          bad++; $display("FAIL out_bit c=%0d k=%0d: got %b want %b", c, k, o_dat, exp_o[N-1-k]);
        end
        if (c % P == CD) oc = {oc[14:0], o_dat};
      end
      if (c == F - 1) begin
        p = '0; r = '0;
        for (int i = 0; i < IW; i++) begin
          if (ph[i] == m_stab[i]) m_cnt[i] = 0;
          else begin
            m_cnt[i] = m_cnt[i] + 1;
            if (m_cnt[i] == DB) begin
              m_cnt[i] = 0; m_stab[i] = ph[i]; p[i] = ph[i]; r[i] = !ph[i];
            end
          end
        end
        m_raw = ph;
        total++;
        if ({done, raw, stab, prs, rel} !== {1'b1, ph, m_stab, p, r}) begin
          bad++; $display("FAIL frame_end: got done=%b raw=%h stab=%h prs=%h rel=%h want done=1 raw=%h stab=%h prs=%h rel=%h",
                          done, raw, stab, prs, rel, ph, m_stab, p, r);
        end
        total++;
        if (oc !== v) begin
          bad++; $display("FAIL out_chain: got %h want %h", oc, v);
        end
      end else begin
        total++;
        if ({done, raw, stab, prs, rel} !== {1'b0, m_raw, m_stab, 42'b0}) begin
          bad++; $display("FAIL idle c=%0d: got done=%b raw=%h stab=%h prs=%h rel=%h want done=0 raw=%h stab=%h no pulses",
                          c, done, raw, stab, prs, rel, m_raw, m_stab);
        end
      end
      if (prs[0] && p0_at < 0) p0_at = fr * F + c;
      n_p3 += int'(prs[3]);
      n_r3 += int'(rel[3]);
      @(posedge clk);
    end
    fr++;
  endtask
  task automatic test_frame;
    test_reset();
    run_frame(16'hA5C3, 21'h1F0F0F, 1, 16'h5A3C);
    run_frame(16'h5A3C, 21'h1F0F0F, 0, 16'h0);
  endtask
  task automatic test_press_latency;
    test_reset();
    repeat (5) run_frame(16'($urandom), 21'h1, 0, 16'h0);
    total++;
    if (p0_at !== 4 * F - 1) begin
      bad++; $display("FAIL press_latency: got %0d want %0d", p0_at, 4 * F - 1);
    end
  endtask
  task automatic test_glitch;
    test_reset();
    repeat (3) run_frame(16'($urandom), 21'h8, 0, 16'h0);
    run_frame(16'($urandom), 21'h0, 0, 16'h0);
    total++;
    if (n_p3 !== 0) begin
      bad++; $display("FAIL glitch_press: got %0d want 0", n_p3);
    end
    repeat (4) run_frame(16'($urandom), 21'h8, 0, 16'h0);
    total++;
    if (n_p3 !== 1 || stab[3] !== 1'b1) begin
      bad++; $display("FAIL steady_press: got %0d/%b want 1/1", n_p3, stab[3]);
    end
    repeat (4) run_frame(16'($urandom), 21'h0, 0, 16'h0);
    total++;
    if (n_r3 !== 1 || stab[3] !== 1'b0) begin
      bad++; $display("FAIL release: got %0d/%b want 1/0", n_r3, stab[3]);
    end
  endtask
  task automatic test_random;
    logic [20:0] ph;
    ph = 21'($urandom);
    for (int f = 0; f < 12; f++) begin
      if (f % 3 != 2) ph = ph ^ (21'($urandom) & 21'($urandom) & 21'($urandom));
      run_frame(16'($urandom), ph, bit'($urandom_range(0, 1)), 16'($urandom));
    end
  endtask
  task automatic test_reset_mid;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if ({sck, o_dat, olat, ilat, done, raw, stab, prs, rel} !== '0) begin
      bad++; $display("FAIL reset_mid: got %h want 0", {sck, o_dat, olat, ilat, done, raw, stab, prs, rel});
    end
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      total++;
      if ({olat, done} !== 2'b00) begin
        bad++; $display("FAIL aborted_latch c=%0d: got %b want 00", c, {olat, done});
      end
    end
    model_clear();
    rst = 0;
    @(posedge clk);
    run_frame(16'h1234, 21'h0ABCDE, 0, 16'h0);
  endtask
  task automatic test_small;
    logic [7:0] e_raw;
    bit e_il, e_ol, e_sck;
    int fc, k;
    b_od = 8'($urandom);
    b_in = 1'b1;
    test_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (c == 20) b_in = 1'b0;
      fc = c % 20;
      e_il = fc < 2;
      e_ol = fc >= 18;
      e_sck = !e_il && !e_ol && fc % 2 == 1;
      total++;
      if ({b_sck, b_ilat, b_olat} !== {e_sck, e_il, e_ol}) begin
        bad++; $display("FAIL small_strobes c=%0d: got %b want %b", c, {b_sck, b_ilat, b_olat}, {e_sck, e_il, e_ol});
      end
      if (!e_il && !e_ol) begin
        k = fc / 2 - 1;
        total++;
        if (b_dat !== b_od[7-k]) begin
          bad++; $display("FAIL small_bit c=%0d: got %b want %b", c, b_dat, b_od[7-k]);
        end
      end
      if (fc == 19) begin
        e_raw = c < 20 ? 8'hFF : 8'h00;
        total++;
        if ({b_done, b_raw, b_stab, b_prs, b_rel} !== {1'b1, e_raw, e_raw, e_raw, ~e_raw}) begin
          bad++; $display("FAIL small_end c=%0d: got done=%b raw=%h stab=%h prs=%h rel=%h want 1 %h %h %h %h",
                          c, b_done, b_raw, b_stab, b_prs, b_rel, e_raw, e_raw, e_raw, ~e_raw);
        end
      end else begin
        total++;
        if ({b_done, b_prs, b_rel} !== 17'b0) begin
          bad++; $display("FAIL small_idle c=%0d: got %b want 0", c, {b_done, b_prs, b_rel});
        end
      end
      @(posedge clk);
    end
  endtask
  initial begin
    test_reset();
    test_frame();
    test_press_latency();
    test_glitch();
    test_random();
    test_reset_mid();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
